// File: rtl/trivium_pkg.sv
// Shared Trivium constants, controller state encoding and the key/IV load mapping.
// State bit s_i (1-based, as in the cipher description) lives at vector index i-1.
package trivium_pkg;

    localparam int unsigned STATE_BITS = 288;
    localparam int unsigned KEY_BITS   = 80;
    localparam int unsigned IV_BITS    = 80;
    localparam int unsigned WARM_STEPS = 1152;
    localparam int unsigned WARM_CNT_W = 11;
    localparam int unsigned IV_OFS     = 93;

    // Output taps; T1B/T2B/T3B are also the last bits of the three shift registers.
    localparam int unsigned T1A = 66;
    localparam int unsigned T1B = 93;
    localparam int unsigned T2A = 162;
    localparam int unsigned T2B = 177;
    localparam int unsigned T3A = 243;
    localparam int unsigned T3B = 288;

    localparam int unsigned A1A = 91;
    localparam int unsigned A1B = 92;
    localparam int unsigned A2A = 175;
    localparam int unsigned A2B = 176;
    localparam int unsigned A3A = 286;
    localparam int unsigned A3B = 287;

    localparam int unsigned FB1 = 171;
    localparam int unsigned FB2 = 264;
    localparam int unsigned FB3 = 69;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWarm,
        StRun,
        StFlush,
        StDone
    } ctrl_state_e;

    function automatic logic [STATE_BITS-1:0] trivium_init(input logic [KEY_BITS-1:0] key,
                                                           input logic [IV_BITS-1:0]  iv);
        logic [STATE_BITS-1:0] s;
        s = '0;
        s[KEY_BITS-1:0] = key;
        s[IV_OFS+IV_BITS-1:IV_OFS] = iv;
        s[STATE_BITS-1:STATE_BITS-3] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_stream_ctrl_if.sv
// Host/consumer bundle for the Trivium stream controller: job request plus keystream handshake.
interface trivium_stream_ctrl_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned LEN_W = 16
);
    import trivium_pkg::*;

    logic                start;
    logic [KEY_BITS-1:0] key;
    logic [IV_BITS-1:0]  iv;
    logic [LEN_W-1:0]    len;
    logic                busy;
    logic [W-1:0]        ks_data;
    logic                ks_valid;
    logic                ks_ready;
    logic                ks_last;
    logic                done;

    modport master (
        output start, key, iv, len, ks_ready,
        input  busy, ks_data, ks_valid, ks_last, done
    );

    modport slave (
        input  start, key, iv, len, ks_ready,
        output busy, ks_data, ks_valid, ks_last, done
    );

endinterface

// File: rtl/trivium_core.sv
// 288-bit Trivium state; z is the keystream bit of the current state, step advances one round.
module trivium_core
    import trivium_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [KEY_BITS-1:0] key,
    input  logic [IV_BITS-1:0]  iv,
    output logic                z
);

    logic [STATE_BITS-1:0] s_q, s_d;
    logic t1, t2, t3;
    logic t1_fb, t2_fb, t3_fb;

    always_comb begin
        t1    = s_q[T1A-1] ^ s_q[T1B-1];
        t2    = s_q[T2A-1] ^ s_q[T2B-1];
        t3    = s_q[T3A-1] ^ s_q[T3B-1];
        z     = t1 ^ t2 ^ t3;
        t1_fb = t1 ^ (s_q[A1A-1] & s_q[A1B-1]) ^ s_q[FB1-1];
        t2_fb = t2 ^ (s_q[A2A-1] & s_q[A2B-1]) ^ s_q[FB2-1];
        t3_fb = t3 ^ (s_q[A3A-1] & s_q[A3B-1]) ^ s_q[FB3-1];
        s_d   = s_q;
        if (load) begin
            s_d = trivium_init(key, iv);
        end else if (step) begin
            // Each register shifts up by one; feedback enters at its first bit.
            s_d = {s_q[STATE_BITS-2:T2B], t2_fb, s_q[T2B-2:T1B], t1_fb, s_q[T1B-2:0], t3_fb};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/trivium_stream_ctrl.sv
// Trivium sequencer: load, warm-up, then pack len keystream bits into W-bit words
// over valid/ready, stalling the core whenever a finished word cannot be handed off.
module trivium_stream_ctrl
    import trivium_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned WARM_N = WARM_STEPS
) (
    input logic                  clk,
    input logic                  reset,
    trivium_stream_ctrl_if.slave bus
);

    localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARM_N - 1);

    ctrl_state_e           state_q, state_d;
    logic [WARM_CNT_W-1:0] warm_q, warm_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [IV_BITS-1:0]    iv_q, iv_d;
    logic [W-1:0]          acc_q, acc_d, acc_bit;
    logic [W-1:0]          mask_q, mask_d;
    logic [W-1:0]          data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  core_load, core_step, core_z;
    logic                  out_free, final_bit, word_done;

    trivium_core u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load),
        .step  (core_step),
        .key   (key_q),
        .iv    (iv_q),
        .z     (core_z)
    );

    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        key_d     = key_q;
        iv_d      = iv_q;
        acc_d     = acc_q;
        mask_d    = mask_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        core_load = 1'b0;
        core_step = 1'b0;

        out_free  = !valid_q || bus.ks_ready;
        acc_bit   = acc_q | (core_z ? mask_q : '0);
        cnt_inc   = cnt_q + LEN_W'(1);
        final_bit = (cnt_inc == len_q);
        word_done = mask_q[W-1] || final_bit;

        if (valid_q && bus.ks_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    key_d   = bus.key;
                    iv_d    = bus.iv;
                    len_d   = bus.len;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                core_load = 1'b1;
                warm_d    = '0;
                cnt_d     = '0;
                acc_d     = '0;
                mask_d    = W'(1);
                state_d   = StWarm;
            end
            StWarm: begin
                core_step = 1'b1;
                if (warm_q == WARM_LAST) begin
                    warm_d  = '0;
                    state_d = (len_q == '0) ? StDone : StRun;
                end else begin
                    warm_d = warm_q + WARM_CNT_W'(1);
                end
            end
            StRun: begin
                // A finished word needs a free output slot, otherwise hold the core.
                if (!word_done || out_free) begin
                    core_step = 1'b1;
                    cnt_d     = cnt_inc;
                    if (word_done) begin
                        data_d  = acc_bit;
                        valid_d = 1'b1;
                        last_d  = final_bit;
                        acc_d   = '0;
                        mask_d  = W'(1);
                        if (final_bit) begin
                            state_d = StFlush;
                        end
                    end else begin
                        acc_d  = acc_bit;
                        mask_d = mask_q << 1;
                    end
                end
            end
            StFlush: begin
                if (out_free) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            warm_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            acc_q   <= '0;
            mask_q  <= W'(1);
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.ks_data  = data_q;
    assign bus.ks_valid = valid_q;
    assign bus.ks_last  = last_q;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Directed bench for trivium_stream_ctrl: a bit-serial Trivium model fills a word scoreboard
// that is drained on every accepted keystream word.
module tb_trivium_stream_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;
    int   errs;
    int   checks;
    exp_t exp_q[$];

    trivium_stream_ctrl_if #(.W(8), .LEN_W(16)) bus ();

    trivium_stream_ctrl #(
        .W      (8),
        .LEN_W  (16),
        .WARM_N (1152)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Trivium written with 1-based state indices, one keystream bit per round.
    task automatic push_expected(input logic [79:0] k, input logic [79:0] v, input int n);
        logic [288:1] s;
        logic         t1, t2, t3, z;
        logic [7:0]   w;
        int           b;
        s          = '0;
        s[80:1]    = k;
        s[173:94]  = v;
        s[288:286] = 3'b111;
        w          = '0;
        b          = 0;
        for (int i = 0; i < 1152 + n; i++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            s[93:1]    = {s[92:1], t3};
            s[177:94]  = {s[176:94], t1};
            s[288:178] = {s[287:178], t2};
            if (i >= 1152) begin
                w = {z, w[7:1]};
                b++;
                if (b == 8 || i == 1152 + n - 1) begin
                    exp_q.push_back('{data: w >> (8 - b), last: (i == 1152 + n - 1)});
                    w = '0;
                    b = 0;
                end
            end
        end
    endtask

    task automatic run_stream(input string tag, input logic [79:0] k, input logic [79:0] v,
                              input logic [15:0] n, input int pct, input bit poke,
                              output int first_valid, output int done_idx,
                              output int busy_cnt);
        int         idx;
        int         done_cnt;
        int         budget;
        bit         stall;
        bit         fin;
        logic [7:0] hold_d;
        logic       hold_l;
        exp_t       e;
        push_expected(k, v, int'(n));
        first_valid = -1;
        done_idx    = -1;
        busy_cnt    = 0;
        done_cnt    = 0;
        stall       = 1'b0;
        fin         = 1'b0;
        hold_d      = '0;
        hold_l      = 1'b0;
        budget      = 1400 + 4 * int'(n);
        @(negedge clk);
        bus.key      = k;
        bus.iv       = v;
        bus.len      = n;
        bus.start    = 1'b1;
        bus.ks_ready = (pct >= 100);
        @(negedge clk);
        bus.start = 1'b0;
        idx       = 1;
        while (!fin) begin
            if (stall) begin
                chk({tag, " stalled valid"}, bus.ks_valid, 1);
                chk({tag, " stalled data"}, bus.ks_data, hold_d);
                chk({tag, " stalled last"}, bus.ks_last, hold_l);
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            if (bus.ks_valid && first_valid < 0) first_valid = idx;
            if (poke && idx == 40) begin
                bus.start = 1'b1;
                bus.key   = ~k;
                bus.len   = 16'd5;
            end else begin
                bus.start = 1'b0;
            end
            bus.ks_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            stall  = bus.ks_valid && !bus.ks_ready;
            hold_d = bus.ks_data;
            hold_l = bus.ks_last;
            if (bus.ks_valid && bus.ks_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected extra word"}, bus.ks_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " word data"}, bus.ks_data, e.data);
                    chk({tag, " word last"}, bus.ks_last, e.last);
                end
            end
            if (done_cnt > 0 && !bus.busy) begin
                fin = 1'b1;
            end else if (idx >= budget) begin
                chk({tag, " busy at cycle budget"}, bus.busy, 0);
                fin = 1'b1;
            end
            idx++;
            @(negedge clk);
        end
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " words outstanding"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int fv, di, bc;

    initial begin
        errs         = 0;
        checks       = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.iv       = '0;
        bus.len      = '0;
        bus.ks_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset ks_valid", bus.ks_valid, 0);
        chk("reset ks_last", bus.ks_last, 0);
        chk("reset done", bus.done, 0);
        chk("reset ks_data", bus.ks_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single full word: fixed latency, last on the only word, done right after.
        run_stream("latency", 80'h0123456789abcdef0123, 80'hfedcba98765432100f0f, 16'd8, 100, 0,
                   fv, di, bc);
        chk("latency first valid cycle", fv, 1162);
        chk("latency done cycle", di, 1163);

        run_stream("golden", 80'h0, 80'h0, 16'd4096, 100, 0, fv, di, bc);

        // Reset in the middle of RUN.
        @(negedge clk);
        bus.key      = 80'h5555aaaa5555aaaa5555;
        bus.iv       = 80'h1;
        bus.len      = 16'd64;
        bus.start    = 1'b1;
        bus.ks_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 1300 && !bus.ks_valid; i++) @(negedge clk);
        chk("midrun reached RUN", bus.ks_valid, 1);
        reset = 1'b0;
        #1;
        chk("midrun reset busy", bus.busy, 0);
        chk("midrun reset ks_valid", bus.ks_valid, 0);
        chk("midrun reset ks_data", bus.ks_data, 0);
        chk("midrun reset ks_last", bus.ks_last, 0);
        chk("midrun reset done", bus.done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrun stays idle", bus.busy, 0);
        chk("midrun no output", bus.ks_valid, 0);

        // Partial final word, with a start pulse during warm-up that must be ignored.
        run_stream("partial", 80'hdeadbeefcafef00d1234, 80'h0badc0de0badc0de0bad, 16'd20, 100, 1,
                   fv, di, bc);
        repeat (3) @(negedge clk);
        chk("partial idle after", bus.busy, 0);

        run_stream("bp_ready1", 80'h13579bdf02468ace1357, 80'h2468ace013579bdf2468, 16'd100,
                   100, 0, fv, di, bc);
        run_stream("bp_ready30", 80'h13579bdf02468ace1357, 80'h2468ace013579bdf2468, 16'd100,
                   30, 0, fv, di, bc);

        run_stream("len0", 80'h1, 80'h2, 16'd0, 100, 0, fv, di, bc);
        chk("len0 busy cycles", bc, 1154);
        chk("len0 any ks_valid", (fv >= 0), 0);
        repeat (3) @(negedge clk);
        chk("len0 idle after", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
